// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer game.
package reaction_pkg;

  localparam int VALUE_W = 14;

  localparam logic [VALUE_W-1:0] MAX_MS    = 14'd9999;
  localparam logic [VALUE_W-1:0] FOUL_CODE = 14'd9999;
  localparam logic [15:0]        LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    GO,
    DONE,
    FOUL
  } state_t;

  // Fibonacci step for taps 16,14,13,11: feedback enters at bit 0
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/rt_lfsr16.sv
// Free-running 16-bit LFSR that supplies the random part of the GO delay.
module rt_lfsr16
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] out
);

  always_ff @(posedge clk) begin
    if (rst) out <= LFSR_SEED;
    else     out <= lfsr_next(out);
  end

endmodule

// File: rtl/reaction_timer_fsm.sv
// Reaction-time game: random GO delay, millisecond counting and false-start detection.
// Define REACTION_BEST_TIME_EN to keep the best (minimum) valid result on best_time.
module reaction_timer_fsm
  import reaction_pkg::*;
#(
  parameter int MS_DIV       = 10000,
  parameter int MIN_DELAY_MS = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn,
  output logic [VALUE_W-1:0] value,
  output logic               led_go,
  output logic               value_valid,
  output logic               too_early,
  output logic [VALUE_W-1:0] best_time
);

  localparam logic [15:0] PRESC_LAST = 16'(MS_DIV - 1);
  localparam logic [15:0] MIN_DELAY  = 16'(MIN_DELAY_MS);

  state_t      state;
  logic        btn_meta;
  logic        btn_sync;
  logic        btn_prev;
  logic        press;
  logic        tick;
  logic [15:0] presc;
  logic [15:0] ms_cnt;
  logic [15:0] delay_ms;
  logic [15:0] lfsr;
  logic [4:0]  lfsr_unused;

`ifdef REACTION_BEST_TIME_EN
  logic [VALUE_W-1:0] best_reg;
  assign best_time = best_reg;
`else
  assign best_time = MAX_MS;
`endif

  rt_lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .out (lfsr)
  );

  assign lfsr_unused = lfsr[15:11];

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
    end
  end

  assign press = btn_sync & ~btn_prev;
  assign tick  = (presc == PRESC_LAST);

  // Every transition also restarts the prescaler so the first tick lands MS_DIV cycles after entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      value       <= '0;
      led_go      <= 1'b0;
      value_valid <= 1'b0;
      too_early   <= 1'b0;
      presc       <= '0;
      ms_cnt      <= '0;
      delay_ms    <= '0;
`ifdef REACTION_BEST_TIME_EN
      best_reg    <= MAX_MS;
`endif
    end else begin
      value_valid <= 1'b0;
      presc       <= tick ? 16'd0 : presc + 16'd1;
      case (state)
        IDLE, DONE, FOUL: begin
          if (press) begin
            state     <= ARM;
            delay_ms  <= MIN_DELAY + {5'd0, lfsr[10:0]};
            ms_cnt    <= '0;
            presc     <= '0;
            too_early <= 1'b0;
            led_go    <= 1'b0;
          end
        end
        ARM: begin
          if (press) begin
            state     <= FOUL;
            value     <= FOUL_CODE;
            too_early <= 1'b1;
            presc     <= '0;
          end else if (tick) begin
            if (ms_cnt + 16'd1 >= delay_ms) begin
              state  <= GO;
              value  <= '0;
              led_go <= 1'b1;
              presc  <= '0;
            end else begin
              ms_cnt <= ms_cnt + 16'd1;
            end
          end
        end
        GO: begin
          // A press on a tick cycle wins, so the displayed count never includes that tick
          if (press) begin
            state       <= DONE;
            led_go      <= 1'b0;
            value_valid <= 1'b1;
            presc       <= '0;
`ifdef REACTION_BEST_TIME_EN
            if (value < best_reg) best_reg <= value;
`endif
          end else if (tick) begin
            if (value == MAX_MS - 14'd1) begin
              state       <= DONE;
              value       <= MAX_MS;
              led_go      <= 1'b0;
              value_valid <= 1'b1;
              presc       <= '0;
            end else begin
              value <= value + 14'd1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          led_go <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/reaction_timer_fsm.md
REACTION_TIMER_FSM -- requirements
Module: reaction_timer_fsm

Interface
REQ-001 Parameter MS_DIV, default 10000, meaning clk cycles per 1 ms tick (10 MHz clk); legal range 2..65535.
REQ-002 Parameter MIN_DELAY_MS, default 1000, meaning fixed part of the random GO delay.
REQ-003 Port clk  input  1  sole clock, all logic on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port btn  input  1  asynchronous player button, active-high.
REQ-006 Port value  output  14  reaction time in ms, 0..9999, sent to the 7-segment driver.
REQ-007 Port led_go  output  1  GO lamp.
REQ-008 Port value_valid  output  1  one-cycle pulse when a final result is latched.
REQ-009 Port too_early  output  1  false-start flag.
REQ-010 Port best_time  output  14  best (minimum) valid result.

Function
REQ-011 btn SHALL pass through a 2-flop synchronizer; press = synced high while previous synced sample low; a btn rise sampled at edge N SHALL change state at edge N+2.
REQ-012 A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) SHALL advance every clk cycle from reset.
REQ-013 A ms prescaler SHALL issue one tick every MS_DIV cycles and SHALL clear on every state entry, so the first tick comes exactly MS_DIV cycles after entry.
REQ-014 States: IDLE, ARM, GO, DONE, FOUL.
REQ-015 IDLE: led_go=0; press -> ARM.
REQ-016 ARM entry SHALL capture delay_ms = MIN_DELAY_MS + lfsr[10:0] and clear ms counter; led_go=0.
REQ-017 ARM: press before delay elapses -> FOUL, value=9999, too_early=1; ms counter == delay_ms -> GO.
REQ-018 GO entry SHALL clear value to 0; led_go=1; value SHALL increment by 1 on each tick (live count).
REQ-019 GO: press -> DONE with value frozen at current count and value_valid=1 for one cycle.
REQ-020 GO: value reaching 9999 SHALL saturate -> DONE with value=9999 and value_valid=1; no wrap to 0.
REQ-021 Press and tick in the same cycle in GO: press wins; value holds the pre-tick count.
REQ-022 DONE/FOUL: led_go=0, value held; press -> ARM and too_early cleared on ARM entry.
REQ-023 Presses in any state other than those listed SHALL be ignored; holding btn high SHALL generate exactly one press.

Reset
REQ-024 rst SHALL force state=IDLE, value=0, led_go=0, value_valid=0, too_early=0, best_time=9999, LFSR=16'hACE1, prescaler and counters=0.
REQ-025 rst asserted mid-round (any state) SHALL abort the round with the same values on the next edge; no result latched.

Configuration
REQ-026 Macro REACTION_BEST_TIME_EN: when defined, best_time SHALL update to value on a value_valid pulse if value < best_time, excluding timeouts (9999) and fouls.
REQ-027 Without REACTION_BEST_TIME_EN, best_time SHALL be constant 9999 and no comparator/register SHALL be synthesized.

Structure
REQ-028 Shared package reaction_pkg SHALL hold the state enum, MAX_MS=9999, FOUL_CODE=9999, LFSR_SEED=16'hACE1, and value width 14.
REQ-029 LFSR SHALL be a sub-module rt_lfsr16 (clk, rst, out[15:0]); prescaler and FSM stay in the top.

Verification (MS_DIV=4, MIN_DELAY_MS=10 for sim)
REQ-030 Reset, press at cycle 20 -> ARM, led_go rises after exactly (10+lfsr[10:0] at ARM entry) ticks x4 cycles.
REQ-031 In GO, press after 37 ticks -> value=37, value_valid high exactly 1 cycle, led_go=0, DONE.
REQ-032 Press during ARM -> FOUL, value=9999, too_early=1; next press -> ARM, too_early=0.
REQ-033 No press in GO -> value counts to 9999, holds, value_valid pulses once, DONE.
REQ-034 With REACTION_BEST_TIME_EN, results 50 then 80 then 30 -> best_time 50, 50, 30; without macro best_time stays 9999.
REQ-035 rst pulse while in GO with value=123 -> next cycle IDLE, value=0, led_go=0, no value_valid.
